// File: rtl/rob_alloc_ctrl_pkg.sv
// rtl/rob_alloc_ctrl_pkg.sv - shared sizing constants and FSM encoding for the ROB allocation controller
package rob_alloc_ctrl_pkg;

  localparam int ROB_DEPTH      = 16;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int FLUSH_CYCLES   = 2;
  localparam int TW             = $clog2(ROB_DEPTH);

  typedef enum logic {
    ROB_CTRL_RUN   = 1'b0,
    ROB_CTRL_FLUSH = 1'b1
  } rob_ctrl_state_e;

endpackage

// File: rtl/rob_ptr_ctr.sv
// rtl/rob_ptr_ctr.sv - wrapping ROB pointer with increment enable and synchronous clear
module rob_ptr_ctr #(
  parameter int DEPTH = 16,
  localparam int W    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // DEPTH is a power of two, so the natural binary rollover is the wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// rtl/rob_alloc_ctrl.sv - ROB tag allocation, retirement and flush sequencing for the RAT
module rob_alloc_ctrl #(
  parameter int ROB_DEPTH      = rob_alloc_ctrl_pkg::ROB_DEPTH,
  parameter int GPR_ADDR_WIDTH = rob_alloc_ctrl_pkg::GPR_ADDR_WIDTH,
  parameter int FLUSH_CYCLES   = rob_alloc_ctrl_pkg::FLUSH_CYCLES,
  localparam int TW            = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dispatch_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] dispatch_dst_addr,
  input  logic                      dispatch_dst_wen,
  output logic                      dispatch_ready,
  output logic                      allocate_en,
  output logic [TW-1:0]             rob_alloc_tag,
  output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr,
  output logic                      rob_alloc_dst_wen,
  input  logic                      head_done,
  input  logic [GPR_ADDR_WIDTH-1:0] head_dst_addr,
  input  logic                      head_dst_wen,
  input  logic                      head_br_taken,
  input  logic                      head_exp,
  output logic                      commit_dst_en,
  output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr,
  output logic [TW-1:0]             rob_commit_Paddr,
  output logic                      rob_commit_br_taken,
  output logic                      rob_commit_exp_en,
  output logic                      flush_busy,
  output logic [TW:0]               rob_count,
  output logic                      rob_empty,
  output logic                      rob_full
);

  import rob_alloc_ctrl_pkg::*;

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  rob_ctrl_state_e state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [TW:0]     count_q;
  logic [TW-1:0]   head_ptr, tail_ptr;
  logic            commit_fire, flush_trigger;

  assign rob_empty   = (count_q == '0);
  assign rob_full    = (count_q == (TW+1)'(ROB_DEPTH));
  assign rob_count   = count_q;
  assign flush_busy  = (state_q == ROB_CTRL_FLUSH);

  assign commit_fire   = (state_q == ROB_CTRL_RUN) & ~rob_empty & head_done;
  assign flush_trigger = commit_fire & (head_br_taken | head_exp);

  // The flushing commit closes dispatch in its own cycle so nothing lands behind the flush
  assign dispatch_ready = (state_q == ROB_CTRL_RUN) & ~rob_full & ~flush_trigger;
  assign allocate_en    = dispatch_valid & dispatch_ready;

  assign rob_alloc_tag      = tail_ptr;
  assign rob_alloc_dst_addr = dispatch_dst_addr;
  assign rob_alloc_dst_wen  = dispatch_dst_wen & (dispatch_dst_addr != '0);

  assign commit_dst_en       = commit_fire & head_dst_wen & (head_dst_addr != '0);
  assign rob_commit_dst_addr = head_dst_addr;
  assign rob_commit_Paddr    = head_ptr;
  assign rob_commit_br_taken = commit_fire & head_br_taken;
  assign rob_commit_exp_en   = commit_fire & head_exp;

  rob_ptr_ctr #(.DEPTH(ROB_DEPTH)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_trigger),
    .inc   (commit_fire),
    .ptr   (head_ptr)
  );

  rob_ptr_ctr #(.DEPTH(ROB_DEPTH)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_trigger),
    .inc   (allocate_en),
    .ptr   (tail_ptr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush_trigger) begin
      count_q <= '0;
    end else if (allocate_en && !commit_fire) begin
      count_q <= count_q + (TW+1)'(1);
    end else if (commit_fire && !allocate_en) begin
      count_q <= count_q - (TW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ROB_CTRL_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ROB_CTRL_RUN: begin
        if (flush_trigger) begin
          state_d = ROB_CTRL_FLUSH;
          fcnt_d  = FCW'(FLUSH_CYCLES - 1);
        end
      end
      ROB_CTRL_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = ROB_CTRL_RUN;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: state_d = ROB_CTRL_RUN;
    endcase
  end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// tb/tb_rob_alloc_ctrl.sv - scoreboard bench for rob_alloc_ctrl
module tb_rob_alloc_ctrl;

  localparam int TW = 4;
  localparam int GW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dispatch_valid;
  logic [GW-1:0] dispatch_dst_addr;
  logic          dispatch_dst_wen;
  logic          dispatch_ready;
  logic          allocate_en;
  logic [TW-1:0] rob_alloc_tag;
  logic [GW-1:0] rob_alloc_dst_addr;
  logic          rob_alloc_dst_wen;
  logic          head_done;
  logic [GW-1:0] head_dst_addr;
  logic          head_dst_wen;
  logic          head_br_taken;
  logic          head_exp;
  logic          commit_dst_en;
  logic [GW-1:0] rob_commit_dst_addr;
  logic [TW-1:0] rob_commit_Paddr;
  logic          rob_commit_br_taken;
  logic          rob_commit_exp_en;
  logic          flush_busy;
  logic [TW:0]   rob_count;
  logic          rob_empty;
  logic          rob_full;

  int checks = 0;
  int failures = 0;

  logic [TW-1:0] exp_tag_q[$];
  logic [TW-1:0] rob_q[$];
  logic [TW-1:0] m_tail;
  logic [TW-1:0] exp_v;
  logic [TW-1:0] got_tag;

  always #5 clk = ~clk;

  rob_alloc_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dispatch_valid      (dispatch_valid),
    .dispatch_dst_addr   (dispatch_dst_addr),
    .dispatch_dst_wen    (dispatch_dst_wen),
    .dispatch_ready      (dispatch_ready),
    .allocate_en         (allocate_en),
    .rob_alloc_tag       (rob_alloc_tag),
    .rob_alloc_dst_addr  (rob_alloc_dst_addr),
    .rob_alloc_dst_wen   (rob_alloc_dst_wen),
    .head_done           (head_done),
    .head_dst_addr       (head_dst_addr),
    .head_dst_wen        (head_dst_wen),
    .head_br_taken       (head_br_taken),
    .head_exp            (head_exp),
    .commit_dst_en       (commit_dst_en),
    .rob_commit_dst_addr (rob_commit_dst_addr),
    .rob_commit_Paddr    (rob_commit_Paddr),
    .rob_commit_br_taken (rob_commit_br_taken),
    .rob_commit_exp_en   (rob_commit_exp_en),
    .flush_busy          (flush_busy),
    .rob_count           (rob_count),
    .rob_empty           (rob_empty),
    .rob_full            (rob_full)
  );

  // Inputs change just after the falling edge; they are consumed at the following rising edge.
  task automatic drive(input logic v, input logic [GW-1:0] da, input logic dw,
                       input logic hd, input logic [GW-1:0] ha, input logic hw,
                       input logic bt, input logic ex);
    @(negedge clk);
    dispatch_valid    = v;
    dispatch_dst_addr = da;
    dispatch_dst_wen  = dw;
    head_done         = hd;
    head_dst_addr     = ha;
    head_dst_wen      = hw;
    head_br_taken     = bt;
    head_exp          = ex;
    #1;
  endtask

  task automatic push_alloc();
    exp_tag_q.push_back(m_tail);
    m_tail = m_tail + 4'd1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dispatch_valid = 0; dispatch_dst_addr = 0; dispatch_dst_wen = 0;
    head_done = 0; head_dst_addr = 0; head_dst_wen = 0; head_br_taken = 0; head_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    m_tail = 0;
    checks++;
    if (dispatch_ready !== 1'b1 || rob_empty !== 1'b1 || rob_full !== 1'b0) begin
      $display("FAIL reset_flags ready=%b empty=%b full=%b want 1 1 0", dispatch_ready, rob_empty, rob_full);
      failures++;
    end
    checks++;
    if (allocate_en !== 1'b0 || commit_dst_en !== 1'b0 || rob_commit_br_taken !== 1'b0 ||
        rob_commit_exp_en !== 1'b0 || flush_busy !== 1'b0) begin
      $display("FAIL reset_enables alloc=%b cdst=%b br=%b exp=%b flush=%b want all 0",
               allocate_en, commit_dst_en, rob_commit_br_taken, rob_commit_exp_en, flush_busy);
      failures++;
    end
    checks++;
    if (rob_alloc_tag !== 4'd0 || rob_count !== 5'd0) begin
      $display("FAIL reset_tag_count tag=%0d count=%0d want 0 0", rob_alloc_tag, rob_count);
      failures++;
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1, GW'(i), 1, 0, 0, 0, 0, 0);
      push_alloc();
      checks++;
      if (allocate_en !== 1'b1) begin
        $display("FAIL fill_alloc_en i=%0d got=%b want 1", i, allocate_en);
        failures++;
      end else begin
        exp_v = exp_tag_q.pop_front();
        got_tag = rob_alloc_tag;
        rob_q.push_back(got_tag);
        if (got_tag !== exp_v) begin
          $display("FAIL fill_tag i=%0d got=%0d want %0d", i, got_tag, exp_v);
          failures++;
        end
      end
      checks++;
      if (rob_alloc_dst_wen !== (i != 0)) begin
        $display("FAIL fill_dst_wen i=%0d got=%b want %b", i, rob_alloc_dst_wen, (i != 0));
        failures++;
      end
    end
    drive(1, 5'd3, 1, 0, 0, 0, 0, 0);
    checks++;
    if (rob_full !== 1'b1 || rob_count !== 5'd16 || dispatch_ready !== 1'b0 || allocate_en !== 1'b0) begin
      $display("FAIL full_state full=%b count=%0d ready=%b alloc=%b want 1 16 0 0",
               rob_full, rob_count, dispatch_ready, allocate_en);
      failures++;
    end
  endtask

  task automatic test_full_commit();
    drive(1, 5'd4, 1, 1, 5'd3, 1, 0, 0);
    exp_v = rob_q.pop_front();
    checks++;
    if (allocate_en !== 1'b0 || commit_dst_en !== 1'b1 || rob_commit_Paddr !== exp_v ||
        rob_commit_dst_addr !== 5'd3) begin
      $display("FAIL full_commit alloc=%b cdst=%b paddr=%0d addr=%0d want 0 1 %0d 3",
               allocate_en, commit_dst_en, rob_commit_Paddr, rob_commit_dst_addr, exp_v);
      failures++;
    end
    drive(1, 5'd4, 1, 0, 0, 0, 0, 0);
    push_alloc();
    checks++;
    if (rob_count !== 5'd15) begin
      $display("FAIL full_commit_count got=%0d want 15", rob_count);
      failures++;
    end
    exp_v = exp_tag_q.pop_front();
    checks++;
    if (allocate_en !== 1'b1 || rob_alloc_tag !== exp_v) begin
      $display("FAIL wrap_alloc alloc=%b tag=%0d want 1 %0d", allocate_en, rob_alloc_tag, exp_v);
      failures++;
    end
    rob_q.push_back(rob_alloc_tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rob_count !== 5'd16 || rob_full !== 1'b1) begin
      $display("FAIL wrap_count count=%0d full=%b want 16 1", rob_count, rob_full);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, 0, 1, 5'd9, 1, 0, 0);
      exp_v = rob_q.pop_front();
      checks++;
      if (rob_commit_Paddr !== exp_v || commit_dst_en !== 1'b1) begin
        $display("FAIL drain_commit i=%0d paddr=%0d cdst=%b want %0d 1", i, rob_commit_Paddr, commit_dst_en, exp_v);
        failures++;
      end
    end
    drive(1, 5'd6, 1, 1, 5'd6, 1, 0, 0);
    push_alloc();
    checks++;
    if (rob_count !== 5'd5) begin
      $display("FAIL b2b_pre_count got=%0d want 5", rob_count);
      failures++;
    end
    exp_v = exp_tag_q.pop_front();
    checks++;
    if (allocate_en !== 1'b1 || rob_alloc_tag !== exp_v) begin
      $display("FAIL b2b_alloc alloc=%b tag=%0d want 1 %0d", allocate_en, rob_alloc_tag, exp_v);
      failures++;
    end
    rob_q.push_back(rob_alloc_tag);
    exp_v = rob_q.pop_front();
    checks++;
    if (rob_commit_Paddr !== exp_v) begin
      $display("FAIL b2b_commit paddr=%0d want %0d", rob_commit_Paddr, exp_v);
      failures++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rob_count !== 5'd5 || rob_alloc_tag !== m_tail || rob_commit_Paddr !== rob_q[0]) begin
      $display("FAIL b2b_post count=%0d tag=%0d head=%0d want 5 %0d %0d",
               rob_count, rob_alloc_tag, rob_commit_Paddr, m_tail, rob_q[0]);
      failures++;
    end
  endtask

  task automatic test_zero_dst();
    drive(0, 0, 0, 1, 5'd0, 1, 0, 0);
    exp_v = rob_q.pop_front();
    checks++;
    if (commit_dst_en !== 1'b0 || rob_commit_Paddr !== exp_v) begin
      $display("FAIL zero_dst cdst=%b paddr=%0d want 0 %0d", commit_dst_en, rob_commit_Paddr, exp_v);
      failures++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rob_commit_Paddr !== rob_q[0] || rob_count !== 5'd4) begin
      $display("FAIL zero_dst_adv head=%0d count=%0d want %0d 4", rob_commit_Paddr, rob_count, rob_q[0]);
      failures++;
    end
  endtask

  task automatic test_branch_flush();
    drive(1, 5'd2, 1, 1, 5'd2, 1, 1, 0);
    exp_v = rob_q.pop_front();
    checks++;
    if (rob_commit_br_taken !== 1'b1 || dispatch_ready !== 1'b0 || allocate_en !== 1'b0 ||
        rob_commit_Paddr !== exp_v) begin
      $display("FAIL br_commit br=%b ready=%b alloc=%b paddr=%0d want 1 0 0 %0d",
               rob_commit_br_taken, dispatch_ready, allocate_en, rob_commit_Paddr, exp_v);
      failures++;
    end
    rob_q.delete();
    m_tail = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 5'd2, 1, 1, 5'd2, 1, 0, 0);
      checks++;
      if (flush_busy !== 1'b1 || rob_count !== 5'd0 || dispatch_ready !== 1'b0 ||
          commit_dst_en !== 1'b0 || allocate_en !== 1'b0) begin
        $display("FAIL flush_hold i=%0d busy=%b count=%0d ready=%b cdst=%b alloc=%b want 1 0 0 0 0",
                 i, flush_busy, rob_count, dispatch_ready, commit_dst_en, allocate_en);
        failures++;
      end
    end
    drive(1, 5'd8, 1, 0, 0, 0, 0, 0);
    push_alloc();
    exp_v = exp_tag_q.pop_front();
    checks++;
    if (flush_busy !== 1'b0 || dispatch_ready !== 1'b1 || allocate_en !== 1'b1 || rob_alloc_tag !== exp_v) begin
      $display("FAIL flush_exit busy=%b ready=%b alloc=%b tag=%0d want 0 1 1 %0d",
               flush_busy, dispatch_ready, allocate_en, rob_alloc_tag, exp_v);
      failures++;
    end
    rob_q.push_back(rob_alloc_tag);
  endtask

  task automatic test_exception_reset();
    drive(0, 0, 0, 1, 5'd7, 1, 0, 1);
    exp_v = rob_q.pop_front();
    checks++;
    if (rob_commit_exp_en !== 1'b1 || commit_dst_en !== 1'b1 || rob_commit_br_taken !== 1'b0 ||
        rob_commit_Paddr !== exp_v) begin
      $display("FAIL exp_commit exp=%b cdst=%b br=%b paddr=%0d want 1 1 0 %0d",
               rob_commit_exp_en, commit_dst_en, rob_commit_br_taken, rob_commit_Paddr, exp_v);
      failures++;
    end
    drive(1, 5'd1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (flush_busy !== 1'b1 || dispatch_ready !== 1'b0) begin
      $display("FAIL exp_flush busy=%b ready=%b want 1 0", flush_busy, dispatch_ready);
      failures++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dispatch_valid = 1'b0;
    #1;
    m_tail = 0;
    checks++;
    if (flush_busy !== 1'b0 || rob_empty !== 1'b1 || dispatch_ready !== 1'b1 || rob_alloc_tag !== 4'd0) begin
      $display("FAIL reset_in_flush busy=%b empty=%b ready=%b tag=%0d want 0 1 1 0",
               flush_busy, rob_empty, dispatch_ready, rob_alloc_tag);
      failures++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_fill();
    test_full_commit();
    test_back_to_back();
    test_zero_dst();
    test_branch_flush();
    test_exception_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
